uart_rx: RTL and testbench

Serial receiver paired with the `uarttx` transmitter; it is the downstream stage that consumes the `tx` line.
- Recovers frames at 16 clocks per bit: 1 start bit, 8 data bits LSB first, 1 parity bit, 1 stop bit.
- Presents the received byte with a one-cycle strobe, plus parity and framing error flags.
- Clocked by the same 16x UART clock as `uarttx`; sits between the pad/loopback line and the command/FIFO logic.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, FSM encoding and parity helper.
// Used by uart_rx and the companion uarttx transmitter.
package uart_pkg;

    localparam int UART_OVERSAMPLE  = 16;
    localparam int UART_DATA_BITS   = 8;
    localparam int UART_SAMPLE_TICK = 7;

    localparam logic [3:0] UART_TICK_LAST = 4'(UART_OVERSAMPLE - 1);
    localparam logic [2:0] UART_IDX_LAST  = 3'(UART_DATA_BITS - 1);

    localparam int UART_PARITY_EVEN = 0;
    localparam int UART_PARITY_ODD  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    function automatic logic uart_parity(
        input logic [7:0] d,
        input logic       odd
    );
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the rx line plus previous-value register
// for falling-edge detection. All flops reset to the idle level (1).
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver: 8 data bits LSB first, parity, stop.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting at ticks 6/7/8.
module uart_rx
    import uart_pkg::*;
#(
    parameter int PARITY_MODE = UART_PARITY_EVEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       rdsig,
    output logic       dataerror,
    output logic       frameerror,
    output logic       busy
);

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_i   (rx),
        .rx_s_o (rx_s),
        .fall_o (fall)
    );

    uart_state_e state_q;
    logic [3:0]  tick_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic [7:0]  dataout_q;
    logic        rdsig_q;
    logic        dataerror_q;
    logic        frameerror_q;
    logic        busy_q;

    logic       bit_val;
    logic       sample_pt;
    logic       tick_last;
    logic [3:0] decide_tick;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    assign decide_tick = 4'(UART_SAMPLE_TICK + 1);

    // hist_q[0] holds tick 6, hist_q[1] tick 7; vote completes at tick 8
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            if (tick_q == decide_tick - 4'd2) hist_q[0] <= rx_s;
            if (tick_q == decide_tick - 4'd1) hist_q[1] <= rx_s;
        end
    end

    assign bit_val = (hist_q[0] & hist_q[1])
                   | (hist_q[0] & rx_s)
                   | (hist_q[1] & rx_s);
`else
    assign decide_tick = 4'(UART_SAMPLE_TICK);
    assign bit_val     = rx_s;
`endif

    assign sample_pt = (tick_q == decide_tick);
    assign tick_last = (tick_q == UART_TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_q       <= 4'd0;
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            dataout_q    <= 8'h00;
            rdsig_q      <= 1'b0;
            dataerror_q  <= 1'b0;
            frameerror_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rdsig_q <= 1'b0;
            if (state_q != ST_IDLE) tick_q <= tick_q + 4'd1;

            unique case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_q <= ST_START;
                        tick_q  <= 4'd0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (sample_pt && bit_val) begin
                        state_q <= ST_IDLE;
                        tick_q  <= 4'd0;
                        busy_q  <= 1'b0;
                    end else if (tick_last) begin
                        state_q <= ST_DATA;
                        idx_q   <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (sample_pt) shift_q[idx_q] <= bit_val;
                    if (tick_last) begin
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == UART_IDX_LAST) state_q <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (sample_pt) par_q <= bit_val;
                    if (tick_last) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    // finish at the sample point so back-to-back starts are seen
                    if (sample_pt) begin
                        dataout_q    <= shift_q;
                        dataerror_q  <= par_q !=
                            uart_parity(shift_q, 1'(PARITY_MODE));
                        frameerror_q <= ~bit_val;
                        rdsig_q      <= 1'b1;
                        state_q      <= ST_IDLE;
                        tick_q       <= 4'd0;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tick_q  <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dataout    = dataout_q;
    assign rdsig      = rdsig_q;
    assign dataerror  = dataerror_q;
    assign frameerror = frameerror_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, errors, glitch,
// break, loopback-style frames and reset mid-frame.
module tb_uart_rx;

    localparam int PM = 0;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 172;
`else
    localparam int LAT = 171;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dataout;
    logic       rdsig;
    logic       dataerror;
    logic       frameerror;
    logic       busy;

    uart_rx #(.PARITY_MODE(PM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .dataout    (dataout),
        .rdsig      (rdsig),
        .dataerror  (dataerror),
        .frameerror (frameerror),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         t0;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   rd_cnt = 0;
    int   busy_cnt = 0;
    logic busy_en = 1'b0;
    logic prev_rd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pop and compare on every rdsig strobe
    always @(negedge clk) begin
        if (busy_en && busy) busy_cnt <= busy_cnt + 1;
        prev_rd <= rdsig;
        if (rst_n && rdsig) begin
            exp_t e;
            rd_cnt <= rd_cnt + 1;
            if (prev_rd) chk("rdsig_back_to_back", 1, 0);
            if (sb.size() == 0) begin
                chk("unexpected_rdsig", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("dataout", dataout, e.d);
                chk("dataerror", dataerror, e.pe);
                chk("frameerror", frameerror, e.fe);
                chk("latency", cyc - e.t0, LAT);
            end
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b);
        rx = b;
        repeat (16) tick1();
    endtask

    task automatic frame(input logic [7:0] d, input logic p,
                         input logic s, input logic pe,
                         input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        e.t0 = cyc;
        sb.push_back(e);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        bit_out(p);
        bit_out(s);
    endtask

    task automatic tx_byte(input logic [7:0] d);
        frame(d, (^d) ^ 1'(PM), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 400) begin
            tick1();
            k++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int rd0;
        logic [7:0] ab;

        repeat (3) tick1();
        chk("rst_dataout", dataout, 8'h00);
        chk("rst_rdsig", rdsig, 0);
        chk("rst_dataerror", dataerror, 0);
        chk("rst_frameerror", frameerror, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (5) tick1();

        frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0);
        bit_out(1'b1);
        drain();
        chk("busy_after_frames", busy, 0);

        frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
        rd0 = rd_cnt;
        rx = 1'b0;
        repeat (400) tick1();
        chk("break_queue_empty", sb.size(), 0);
        chk("break_no_retrigger", rd_cnt - rd0, 0);
        chk("break_busy", busy, 0);
        rx = 1'b1;
        repeat (32) tick1();

        rd0 = rd_cnt;
        busy_en = 1'b1;
        rx = 1'b0;
        repeat (4) tick1();
        rx = 1'b1;
        repeat (40) tick1();
        busy_en = 1'b0;
        chk("glitch_busy_len_ok", (busy_cnt >= 7 && busy_cnt <= 10), 1);
        chk("glitch_no_rdsig", rd_cnt - rd0, 0);
        chk("glitch_idle", busy, 0);

        tx_byte(8'h00);
        tx_byte(8'hFF);
        tx_byte(8'h3C);
        bit_out(1'b1);
        drain();

        frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b1);
        bit_out(1'b1);
        drain();

        ab = 8'h99;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(ab[i]);
        rx = ab[4];
        repeat (8) tick1();
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_dataout", dataout, 8'h00);
        chk("midrst_rdsig", rdsig, 0);
        chk("midrst_dataerror", dataerror, 0);
        chk("midrst_frameerror", frameerror, 0);
        chk("midrst_busy", busy, 0);
        rx = 1'b1;
        repeat (3) tick1();
        rst_n = 1'b1;
        repeat (20) tick1();

        frame(8'hC6, 1'b0, 1'b1, 1'b0, 1'b0);
        bit_out(1'b1);
        drain();
        chk("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
